// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   Run/pause/clear/lap controller for the 4-digit stopwatch datapath.
//   Synchronizes and debounces the raw board buttons and direction switch,
//   runs the IDLE/RUN/PAUSE/LAP state machine and divides clk into the
//   count tick that strobes the stopwatch.
//
// Parameters
//   TICK_DIV    clk cycles per count tick (>= 2)
//   DEB_CYCLES  consecutive stable cycles needed to accept a new level (>= 1)
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high
//   btn_start_stop  in   raw button: run/pause toggle
//   btn_clear       in   raw button: stop and zero
//   btn_lap         in   raw button: freeze/unfreeze displayed value
//   dir_sw          in   raw switch: 1 = count up, 0 = count down
//   at_limit        in   stopwatch is at its terminal count for this direction
//   sw_enable       out  one-cycle count strobe
//   sw_up           out  count direction
//   sw_clear        out  one-cycle zero request
//   lap_hold        out  display path holds its captured digits
//   state           out  00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic       dir_sw,
  input  logic       at_limit,
  output logic       sw_enable,
  output logic       sw_up,
  output logic       sw_clear,
  output logic       lap_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  // Channel order inside the conditioning vectors.
  localparam int CH_START = 0;
  localparam int CH_CLEAR = 1;
  localparam int CH_LAP   = 2;
  localparam int CH_DIR   = 3;

  // -------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, then a per-channel debouncer.
  // -------------------------------------------------------------------------
  logic [3:0]    raw, sync1, sync2, deb, flip;
  logic [DW-1:0] deb_cnt [4];
  logic [2:0]    press;

  assign raw = {dir_sw, btn_lap, btn_clear, btn_start_stop};

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A channel flips on the DEB_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      flip[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == DEB_LAST);
    end
  end

  // NOTE: deb_cnt is an array of small control counters, not storage, so it
  // is reset along with the rest of the control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      // Press is a registered pulse on a debounced 0->1 edge only.
      press <= flip[2:0] & sync2[2:0];
      for (int i = 0; i < 4; i++) begin
        if ((sync2[i] == deb[i]) || flip[i]) deb_cnt[i] <= '0;
        else                                 deb_cnt[i] <= deb_cnt[i] + 1'b1;
        if (flip[i]) deb[i] <= sync2[i];
      end
    end
  end

  // Coincident presses: clear > start_stop > lap.
  logic p_clear, p_start, p_lap;
  assign p_clear = press[CH_CLEAR];
  assign p_start = press[CH_START] & ~press[CH_CLEAR];
  assign p_lap   = press[CH_LAP] & ~press[CH_START] & ~press[CH_CLEAR];

  // -------------------------------------------------------------------------
  // State machine and prescaler
  // -------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic          running, tick_due, advance, clear_d;

  assign running  = (state_q == RUN) || (state_q == LAP);
  assign tick_due = running && (presc == TICK_LAST);
  // A cycle that leaves RUN/LAP on a press does not count, so the prescaler
  // phase is preserved exactly across a pause.
  assign advance  = running && !(p_clear || p_start);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_clear)      clear_d = 1'b1;
        else if (p_start) state_d = RUN;
      end
      RUN, LAP: begin
        if (p_clear) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (tick_due && at_limit) begin
          state_d = PAUSE;
        end else if (p_start) begin
          state_d = PAUSE;
        end else if (p_lap) begin
          state_d = (state_q == RUN) ? LAP : RUN;
        end
      end
      PAUSE: begin
        if (p_clear) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (p_start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc     <= '0;
      sw_enable <= 1'b0;
      sw_up     <= 1'b1;
      sw_clear  <= 1'b0;
      lap_hold  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_clear  <= clear_d;
      lap_hold  <= (state_d == LAP);
      // At the terminal count the tick is swallowed and the FSM pauses.
      sw_enable <= tick_due && advance && !at_limit;
      if (state_q == IDLE) sw_up <= deb[CH_DIR];
      if (state_q == IDLE) presc <= '0;
      else if (advance)    presc <= tick_due ? '0 : presc + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl (TICK_DIV=4, DEB_CYCLES=3). Each stimulus
//   step pushes the outputs it expects, tagged with the cycle they are due,
//   onto a scoreboard queue; every clock the due entries are popped and
//   compared against the DUT.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;
  localparam int LAT        = DEB_CYCLES + 3;   // raw rise -> FSM update

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  localparam int B_START = 0;
  localparam int B_CLEAR = 1;
  localparam int B_LAP   = 2;

  typedef enum int {S_STATE, S_EN, S_UP, S_CLR, S_HOLD} sig_t;

  typedef struct {
    int         cyc;
    sig_t       sig;
    logic [1:0] val;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic       dir_sw;
  logic       at_limit;
  logic       sw_enable, sw_up, sw_clear, lap_hold;
  logic [1:0] state;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn[B_START]),
    .btn_clear      (btn[B_CLEAR]),
    .btn_lap        (btn[B_LAP]),
    .dir_sw         (dir_sw),
    .at_limit       (at_limit),
    .sw_enable      (sw_enable),
    .sw_up          (sw_up),
    .sw_clear       (sw_clear),
    .lap_hold       (lap_hold),
    .state          (state)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] observe(sig_t s);
    logic [1:0] v;
    v = 2'b00;
    case (s)
      S_STATE: v = state;
      S_EN:    v = {1'b0, sw_enable};
      S_UP:    v = {1'b0, sw_up};
      S_CLR:   v = {1'b0, sw_clear};
      S_HOLD:  v = {1'b0, lap_hold};
      default: v = 2'bxx;
    endcase
    return v;
  endfunction

  task automatic exp_at(input int c, input sig_t s, input logic [1:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_range(input int c0, input int c1, input sig_t s,
                           input logic [1:0] v, input string tag);
    for (int c = c0; c <= c1; c++) exp_at(c, s, v, tag);
  endtask

  // One clock; sample 1 time unit after the edge and pop everything due now.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [1:0] o;
        o = observe(sb[i].sig);
        n_tests++;
        assert (o === sb[i].val) else begin
          n_fail++;
          $error("FAIL %s @cycle %0d: observed %0d, expected %0d",
                 sb[i].tag, cyc, o, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  // Hold the pressed buttons long enough to debounce, release, and wait for
  // the debounced level to fall again so the next press is a clean edge.
  task automatic release_after();
    repeat (6) step();
    btn = '0;
    repeat (6) step();
  endtask

  // First tick strobe strictly after cycle 'after', given a known tick cycle.
  function automatic int next_pulse(input int ph, input int after);
    int t;
    t = ph;
    while (t <= after) t += TICK_DIV;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t, e0, p, ph, c;

    btn      = '0;
    dir_sw   = 1'b1;
    at_limit = 1'b0;
    reset    = 1'b1;

    // ---- reset values -----------------------------------------------------
    exp_at(2, S_STATE, ST_IDLE, "rst_state");
    exp_at(2, S_EN,    2'd0,    "rst_enable");
    exp_at(2, S_UP,    2'd1,    "rst_up");
    exp_at(2, S_CLR,   2'd0,    "rst_clear");
    exp_at(2, S_HOLD,  2'd0,    "rst_hold");
    step();
    step();
    reset = 1'b0;
    // Debounced dir starts at 0 and reaches 1 five cycles after reset ends.
    exp_at(3, S_UP, 2'd0, "up_idle_deb_low");
    exp_at(7, S_UP, 2'd0, "up_idle_deb_wait");
    exp_at(8, S_UP, 2'd1, "up_idle_deb_high");
    repeat (6) step();

    // ---- glitches do not press --------------------------------------------
    btn[B_START] = 1'b1;
    exp_range(cyc + 1, cyc + 12, S_STATE, ST_IDLE, "glitch_idle");
    repeat (2) step();
    btn[B_START] = 1'b0;
    repeat (10) step();

    exp_range(cyc + 1, cyc + 26, S_STATE, ST_IDLE, "toggle_idle");
    for (int i = 0; i < 10; i++) begin
      btn[B_START] = ~btn[B_START];
      repeat (2) step();
    end
    repeat (6) step();

    // ---- start latency and tick rate --------------------------------------
    r = cyc;
    btn[B_START] = 1'b1;
    e0 = r + LAT;
    exp_at(e0 - 1, S_STATE, ST_IDLE, "start_lat_before");
    exp_at(e0,     S_STATE, ST_RUN,  "start_lat");
    exp_range(e0, e0 + 3, S_EN, 2'd0, "tick_gap0");
    exp_at(e0 + 4, S_EN, 2'd1, "tick_first");
    exp_range(e0 + 5, e0 + 7, S_EN, 2'd0, "tick_gap1");
    exp_at(e0 + 8, S_EN, 2'd1, "tick_second");
    release_after();
    repeat (2) step();

    // ---- pause two cycles into a tick period, then resume ------------------
    while (((cyc - e0) % TICK_DIV) != 1) step();
    r = cyc;
    btn[B_START] = 1'b1;
    p = r + LAT;
    exp_at(p - 3, S_EN, 2'd1, "pause_last_tick");
    exp_at(p - 1, S_STATE, ST_RUN,   "pause_before");
    exp_at(p,     S_STATE, ST_PAUSE, "pause_enter");
    exp_range(p - 2, p + 5, S_EN, 2'd0, "pause_no_tick");
    release_after();
    repeat (2) step();

    r = cyc;
    btn[B_START] = 1'b1;
    t = r + LAT;
    exp_range(cyc + 1, t - 1, S_STATE, ST_PAUSE, "pause_hold");
    exp_range(cyc + 1, t + 1, S_EN, 2'd0, "resume_gap");
    exp_at(t,     S_STATE, ST_RUN, "resume_run");
    exp_at(t + 2, S_EN, 2'd1, "resume_tick");
    exp_range(t + 3, t + 5, S_EN, 2'd0, "resume_gap2");
    exp_at(t + 6, S_EN, 2'd1, "resume_tick2");
    ph = t + 2;
    release_after();
    step();

    // ---- lap freeze / unfreeze, clear from LAP -----------------------------
    r = cyc;
    btn[B_LAP] = 1'b1;
    t = r + LAT;
    exp_at(t - 1, S_HOLD, 2'd0, "lap_hold_before");
    exp_at(t, S_STATE, ST_LAP, "lap_enter");
    exp_at(t, S_HOLD, 2'd1, "lap_hold_set");
    c = next_pulse(ph, t);
    exp_at(c,     S_EN, 2'd1, "lap_tick");
    exp_at(c + 4, S_EN, 2'd1, "lap_tick2");
    release_after();

    r = cyc;
    btn[B_LAP] = 1'b1;
    t = r + LAT;
    exp_at(t - 1, S_STATE, ST_LAP, "lap_still");
    exp_at(t - 1, S_HOLD, 2'd1, "lap_hold_still");
    exp_at(t, S_STATE, ST_RUN, "lap_exit");
    exp_at(t, S_HOLD, 2'd0, "lap_hold_clr");
    c = next_pulse(ph, t);
    exp_at(c, S_EN, 2'd1, "lap_exit_tick");
    release_after();

    r = cyc;
    btn[B_LAP] = 1'b1;
    t = r + LAT;
    exp_at(t, S_STATE, ST_LAP, "lap_again");
    release_after();

    r = cyc;
    btn[B_CLEAR] = 1'b1;
    t = r + LAT;
    exp_at(t - 1, S_CLR,  2'd0, "clear_before");
    exp_at(t - 1, S_HOLD, 2'd1, "clear_hold_before");
    exp_at(t, S_STATE, ST_IDLE, "clear_from_lap");
    exp_at(t, S_CLR,  2'd1, "clear_pulse");
    exp_at(t, S_HOLD, 2'd0, "clear_hold");
    exp_at(t + 1, S_CLR, 2'd0, "clear_one_cycle");
    exp_range(t, t + 5, S_EN, 2'd0, "idle_no_tick");
    release_after();

    // ---- direction frozen outside IDLE -------------------------------------
    r = cyc;
    btn[B_START] = 1'b1;
    t = r + LAT;
    exp_at(t, S_STATE, ST_RUN, "run_dir");
    release_after();

    dir_sw = 1'b0;
    exp_range(cyc + 6, cyc + 8, S_UP, 2'd1, "up_frozen_run");
    repeat (8) step();

    r = cyc;
    btn[B_CLEAR] = 1'b1;
    t = r + LAT;
    exp_at(t, S_STATE, ST_IDLE, "clear_run");
    exp_at(t,     S_UP, 2'd1, "up_frozen_edge");
    exp_at(t + 1, S_UP, 2'd0, "up_idle_follow");
    release_after();

    dir_sw = 1'b1;
    exp_at(cyc + 5, S_UP, 2'd0, "up_deb_wait");
    exp_at(cyc + 6, S_UP, 2'd1, "up_deb_follow");
    repeat (6) step();

    // ---- terminal count pauses without a strobe ----------------------------
    at_limit = 1'b1;
    r = cyc;
    btn[B_START] = 1'b1;
    t = r + LAT;
    exp_at(t,     S_STATE, ST_RUN,   "limit_run");
    exp_at(t + 3, S_STATE, ST_RUN,   "limit_run_hold");
    exp_at(t + 4, S_STATE, ST_PAUSE, "limit_pause");
    exp_range(t, t + 6, S_EN, 2'd0, "limit_no_tick");
    release_after();
    at_limit = 1'b0;

    // ---- coincident clear + start from RUN ---------------------------------
    r = cyc;
    btn[B_START] = 1'b1;
    t = r + LAT;
    exp_at(t, S_STATE, ST_RUN, "resume_after_limit");
    exp_at(t + 4, S_EN, 2'd1, "tick_after_limit");
    release_after();

    r = cyc;
    btn[B_START] = 1'b1;
    btn[B_CLEAR] = 1'b1;
    t = r + LAT;
    exp_at(t,     S_STATE, ST_IDLE, "clear_beats_start");
    exp_at(t,     S_CLR, 2'd1, "coinc_clear_pulse");
    exp_at(t + 1, S_CLR, 2'd0, "coinc_clear_one");
    exp_at(t + 2, S_STATE, ST_IDLE, "coinc_stays_idle");
    release_after();

    // ---- reset while in LAP -------------------------------------------------
    r = cyc;
    dir_sw = 1'b0;
    btn[B_START] = 1'b1;
    t = r + LAT;
    exp_at(t, S_STATE, ST_RUN, "run_pre_reset");
    exp_at(t, S_UP, 2'd0, "up_down_run");
    release_after();

    r = cyc;
    btn[B_LAP] = 1'b1;
    t = r + LAT;
    exp_at(t, S_STATE, ST_LAP, "lap_pre_reset");
    exp_at(t, S_HOLD, 2'd1, "hold_pre_reset");
    release_after();

    reset = 1'b1;
    c = cyc + 1;
    exp_at(c, S_STATE, ST_IDLE, "rst_lap_state");
    exp_at(c, S_EN,    2'd0,    "rst_lap_enable");
    exp_at(c, S_UP,    2'd1,    "rst_lap_up");
    exp_at(c, S_CLR,   2'd0,    "rst_lap_clear");
    exp_at(c, S_HOLD,  2'd0,    "rst_lap_hold");
    step();
    reset = 1'b0;
    exp_at(cyc + 1, S_CLR, 2'd0, "rst_no_clear");
    exp_range(cyc + 1, cyc + 3, S_STATE, ST_IDLE, "rst_stays_idle");
    repeat (4) step();

    // Anything still queued was never reached.
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: due at cycle %0d, never compared (observed none, expected %0d)",
               sb[i].tag, sb[i].cyc, sb[i].val);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
